// File: rtl/regfile_sb_param.sv
// Parametrised register file with N read ports, one write-back port and a per-register
// pending scoreboard. The state edge is selectable, and read ports can forward write-back data.

module regfile_rd_lane #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int AW     = 5,
    parameter int BYPASS = 1
) (
    input  logic [NREGS-1:0][XLEN-1:0] regs,
    input  logic [NREGS-1:0]           pend,
    input  logic [AW-1:0]              addr,
    input  logic                       wb_ok,
    input  logic [AW-1:0]              wb_addr,
    input  logic [XLEN-1:0]            wb_data,
    output logic [XLEN-1:0]            data,
    output logic                       busy
);
    always_comb begin
        data = regs[addr];
        busy = pend[addr];
        if (addr == '0) begin
            data = '0;
            busy = 1'b0;
        end else if ((BYPASS != 0) && wb_ok && (wb_addr == addr)) begin
            // Same-cycle reservations are deliberately not forwarded; only the write is.
            data = wb_data;
            busy = 1'b0;
        end
    end
endmodule

module regfile_sb_param #(
    parameter int  XLEN       = 32,
    parameter int  NREGS      = 32,
    parameter int  NREAD      = 2,
    parameter int  BYPASS     = 1,
    parameter int  WR_NEGEDGE = 1,
    localparam int AW         = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREAD*AW-1:0]   rd_addr,
    output logic [NREAD*XLEN-1:0] rd_data,
    output logic [NREAD-1:0]      rd_busy,
    input  logic                  wb_en,
    input  logic [AW-1:0]         wb_addr,
    input  logic [XLEN-1:0]       wb_data,
    input  logic                  rsv_en,
    input  logic [AW-1:0]         rsv_addr,
    input  logic                  flush,
    output logic [AW:0]           pend_cnt
);
    logic [NREGS-1:0][XLEN-1:0] regs_q, regs_d;
    logic [NREGS-1:0]           pend_q, pend_d;
    logic [AW:0]                cnt_q, cnt_d;
    logic                       wb_ok, rsv_ok;

    assign wb_ok  = wb_en && (wb_addr != '0);
    assign rsv_ok = rsv_en && (rsv_addr != '0);

    // Order matters: flush, then write-back clears, then reserve sets (new producer wins).
    always_comb begin
        regs_d = regs_q;
        pend_d = flush ? '0 : pend_q;
        cnt_d  = flush ? '0 : cnt_q;
        if (wb_ok) begin
            regs_d[wb_addr] = wb_data;
            if (pend_d[wb_addr]) begin
                pend_d[wb_addr] = 1'b0;
                cnt_d           = cnt_d - (AW+1)'(1);
            end
        end
        if (rsv_ok && !pend_d[rsv_addr]) begin
            pend_d[rsv_addr] = 1'b1;
            cnt_d            = cnt_d + (AW+1)'(1);
        end
    end

    generate
        if (WR_NEGEDGE != 0) begin : g_neg
            always_ff @(negedge clk or negedge rst) begin
                if (!rst) begin
                    regs_q <= '0;
                    pend_q <= '0;
                    cnt_q  <= '0;
                end else begin
                    regs_q <= regs_d;
                    pend_q <= pend_d;
                    cnt_q  <= cnt_d;
                end
            end
        end else begin : g_pos
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    regs_q <= '0;
                    pend_q <= '0;
                    cnt_q  <= '0;
                end else begin
                    regs_q <= regs_d;
                    pend_q <= pend_d;
                    cnt_q  <= cnt_d;
                end
            end
        end
    endgenerate

    assign pend_cnt = cnt_q;

    generate
        for (genvar p = 0; p < NREAD; p++) begin : g_rd
            regfile_rd_lane #(
                .XLEN  (XLEN),
                .NREGS (NREGS),
                .AW    (AW),
                .BYPASS(BYPASS)
            ) u_lane (
                .regs   (regs_q),
                .pend   (pend_q),
                .addr   (rd_addr[p*AW +: AW]),
                .wb_ok  (wb_ok),
                .wb_addr(wb_addr),
                .wb_data(wb_data),
                .data   (rd_data[p*XLEN +: XLEN]),
                .busy   (rd_busy[p])
            );
        end
    endgenerate
endmodule
